// File: rtl/irq_request_ctrl_pkg.sv
// Shared constants, FSM state encoding and helpers for the interrupt request front-end.
package irq_request_ctrl_pkg;

  localparam int N_IRQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  function automatic logic [N_IRQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    return {{(N_IRQ-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/irq_request_ctrl_if.sv
// Bundle of request, mask, encoder and CPU handshake signals around the interrupt front-end.
interface irq_request_ctrl_if;
  import irq_request_ctrl_pkg::*;

  logic [N_IRQ-1:0] irq_in;
  logic             mask_we;
  logic [N_IRQ-1:0] mask_wdata;
  logic [N_IRQ-1:0] mask;
  logic [N_IRQ-1:0] req_vec;
  logic [IDX_W-1:0] enc_y;
  logic             enc_valid;
  logic             int_out;
  logic [IDX_W-1:0] int_vec;
  logic             int_ack;
  logic             eoi;
  logic [N_IRQ-1:0] in_service;
  logic             busy;

  // The controller side
  modport slave (
    input  irq_in, mask_we, mask_wdata, enc_y, enc_valid, int_ack, eoi,
    output mask, req_vec, int_out, int_vec, in_service, busy
  );

  // Sources, encoder and CPU side
  modport master (
    output irq_in, mask_we, mask_wdata, enc_y, enc_valid, int_ack, eoi,
    input  mask, req_vec, int_out, int_vec, in_service, busy
  );

endinterface

// File: rtl/irq_request_ctrl_edge_detect.sv
// Rising-edge detector for the request lines; rise is high for one cycle after a 0->1 transition.
module irq_edge_detect
  import irq_request_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_in,
  output logic [N_IRQ-1:0] rise
);

  logic [N_IRQ-1:0] irq_prev;

  // Reset loads the live line levels so lines already high at reset release raise nothing
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_prev <= irq_in;
    end else begin
      irq_prev <= irq_in;
    end
  end

  assign rise = irq_in & ~irq_prev;

endmodule

// File: rtl/irq_request_ctrl.sv
// Interrupt request front-end: edge capture, masking, and the request/ack/EOI handshake with the CPU.
module irq_request_ctrl
  import irq_request_ctrl_pkg::*;
(
  input logic              clk,
  input logic              rst,
  irq_request_ctrl_if.slave bus
);

  state_t           state;
  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] pending_next;
  logic [N_IRQ-1:0] mask_q;
  logic [N_IRQ-1:0] in_service_q;
  logic [N_IRQ-1:0] rise;
  logic             int_out_q;
  logic [IDX_W-1:0] int_vec_q;
  logic             ack_take;
  logic             eoi_take;

  irq_edge_detect u_edge_detect (
    .clk    (clk),
    .rst    (rst),
    .irq_in (bus.irq_in),
    .rise   (rise)
  );

  assign ack_take = (state == ST_ASSERT)  && bus.int_ack;
  assign eoi_take = (state == ST_SERVICE) && bus.eoi;

  // A new edge on the acknowledged line in the same cycle keeps its pending bit set
  always_comb begin
    pending_next = pending;
    if (ack_take) begin
      pending_next[int_vec_q] = 1'b0;
    end
    pending_next = pending_next | rise;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      pending      <= '0;
      mask_q       <= '0;
      in_service_q <= '0;
      int_out_q    <= 1'b0;
      int_vec_q    <= '0;
    end else begin
      pending <= pending_next;
      if (bus.mask_we) begin
        mask_q <= bus.mask_wdata;
      end
      case (state)
        ST_IDLE: begin
          if (bus.enc_valid) begin
            int_vec_q <= bus.enc_y;
            int_out_q <= 1'b1;
            state     <= ST_ASSERT;
          end
        end
        // Vector stays frozen here even if its line gets masked or outranked
        ST_ASSERT: begin
          if (ack_take) begin
            in_service_q <= idx_to_onehot(int_vec_q);
            int_out_q    <= 1'b0;
            state        <= ST_SERVICE;
          end
        end
        ST_SERVICE: begin
          if (eoi_take) begin
            in_service_q <= '0;
            state        <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.mask       = mask_q;
  assign bus.req_vec    = pending & ~mask_q;
  assign bus.int_out    = int_out_q;
  assign bus.int_vec    = int_vec_q;
  assign bus.in_service = in_service_q;
  assign bus.busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_irq_request_ctrl.sv
// Directed bench for irq_request_ctrl with a behavioural priority encoder and an expected-value queue.
module tb_irq_request_ctrl;
  import irq_request_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  irq_request_ctrl_if bus ();

  irq_request_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Stand-in for the 8-to-3 encoder: highest set line wins
  logic [IDX_W-1:0] enc_y_m;
  logic             enc_valid_m;

  always_comb begin
    enc_y_m     = '0;
    enc_valid_m = 1'b0;
    for (int i = 0; i < N_IRQ; i++) begin
      if (bus.req_vec[i]) begin
        enc_y_m     = IDX_W'(i);
        enc_valid_m = 1'b1;
      end
    end
  end

  assign bus.enc_y     = enc_y_m;
  assign bus.enc_valid = enc_valid_m;

  typedef struct {
    string      tag;
    logic       io;
    logic [2:0] iv;
    logic [7:0] isv;
    logic [7:0] rv;
    logic       bz;
    logic [7:0] mk;
  } exp_t;

  exp_t sb[$];
  int   test_count = 0;
  int   fail_count = 0;

  task automatic applyStimulus(input string tag, input logic [7:0] irq, input logic ack,
                               input logic e, input logic r, input logic mw, input logic [7:0] mwd,
                               input logic io, input logic [2:0] iv, input logic [7:0] isv,
                               input logic [7:0] rv, input logic bz, input logic [7:0] mk);
    exp_t x;
    bus.irq_in     = irq;
    bus.int_ack    = ack;
    bus.eoi        = e;
    rst            = r;
    bus.mask_we    = mw;
    bus.mask_wdata = mwd;
    x.tag = tag;
    x.io  = io;
    x.iv  = iv;
    x.isv = isv;
    x.rv  = rv;
    x.bz  = bz;
    x.mk  = mk;
    sb.push_back(x);
  endtask

  task automatic checkOutput();
    exp_t x;
    test_count++;
    assert (sb.size() != 0) else begin
      fail_count++;
      $error("[TB] FAIL scoreboard_empty observed=0 entries expected=1 entry");
    end
    if (sb.size() != 0) begin
      x = sb.pop_front();
      test_count++;
      assert (bus.int_out === x.io) else begin
        fail_count++;
        $error("[TB] FAIL %s int_out observed=%0b expected=%0b", x.tag, bus.int_out, x.io);
      end
      test_count++;
      assert (bus.int_vec === x.iv) else begin
        fail_count++;
        $error("[TB] FAIL %s int_vec observed=%0d expected=%0d", x.tag, bus.int_vec, x.iv);
      end
      test_count++;
      assert (bus.in_service === x.isv) else begin
        fail_count++;
        $error("[TB] FAIL %s in_service observed=%h expected=%h", x.tag, bus.in_service, x.isv);
      end
      test_count++;
      assert (bus.req_vec === x.rv) else begin
        fail_count++;
        $error("[TB] FAIL %s req_vec observed=%h expected=%h", x.tag, bus.req_vec, x.rv);
      end
      test_count++;
      assert (bus.busy === x.bz) else begin
        fail_count++;
        $error("[TB] FAIL %s busy observed=%0b expected=%0b", x.tag, bus.busy, x.bz);
      end
      test_count++;
      assert (bus.mask === x.mk) else begin
        fail_count++;
        $error("[TB] FAIL %s mask observed=%h expected=%h", x.tag, bus.mask, x.mk);
      end
    end
  endtask

  // Drive before a rising edge, check 1 time unit after it, return to the falling edge
  task automatic step(input string tag, input logic [7:0] irq, input logic ack,
                      input logic e, input logic r, input logic mw, input logic [7:0] mwd,
                      input logic io, input logic [2:0] iv, input logic [7:0] isv,
                      input logic [7:0] rv, input logic bz, input logic [7:0] mk);
    applyStimulus(tag, irq, ack, e, r, mw, mwd, io, iv, isv, rv, bz, mk);
    @(posedge clk);
    #1;
    checkOutput();
    @(negedge clk);
  endtask

  // Argument order: tag, irq, ack, eoi, rst, mask_we, mask_wdata | int_out, int_vec, in_service, req_vec, busy, mask
  initial begin
    $display("[TB] starting irq_request_ctrl bench");

    step("rst0", 8'h04, 0, 0, 1, 0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 0, 8'h00);
    step("rst1", 8'h04, 0, 0, 1, 0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 0, 8'h00);
    for (int i = 0; i < 10; i++) begin
      step("held_at_reset", 8'h04, 0, 0, 0, 0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 0, 8'h00);
    end

    step("fall",     8'h00, 0, 0, 0, 0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 0, 8'h00);
    step("rise5",    8'h20, 0, 0, 0, 0, 8'h00, 0, 3'd0, 8'h00, 8'h20, 0, 8'h00);
    step("assert5",  8'h20, 0, 0, 0, 0, 8'h00, 1, 3'd5, 8'h00, 8'h20, 1, 8'h00);
    step("hold5",    8'h20, 0, 0, 0, 0, 8'h00, 1, 3'd5, 8'h00, 8'h20, 1, 8'h00);
    step("ack5",     8'h20, 1, 0, 0, 0, 8'h00, 0, 3'd5, 8'h20, 8'h00, 1, 8'h00);
    step("svc5",     8'h20, 0, 0, 0, 0, 8'h00, 0, 3'd5, 8'h20, 8'h00, 1, 8'h00);
    step("eoi5",     8'h20, 0, 1, 0, 0, 8'h00, 0, 3'd5, 8'h00, 8'h00, 0, 8'h00);
    step("idle5",    8'h20, 0, 0, 0, 0, 8'h00, 0, 3'd5, 8'h00, 8'h00, 0, 8'h00);

    step("quiet3",   8'h00, 0, 0, 0, 0, 8'h00, 0, 3'd5, 8'h00, 8'h00, 0, 8'h00);
    step("rise16",   8'h42, 0, 0, 0, 0, 8'h00, 0, 3'd5, 8'h00, 8'h42, 0, 8'h00);
    step("prio6",    8'h42, 0, 0, 0, 0, 8'h00, 1, 3'd6, 8'h00, 8'h42, 1, 8'h00);
    step("hold6",    8'hC2, 0, 0, 0, 0, 8'h00, 1, 3'd6, 8'h00, 8'hC2, 1, 8'h00);
    step("ack6",     8'hC2, 1, 0, 0, 0, 8'h00, 0, 3'd6, 8'h40, 8'h82, 1, 8'h00);
    step("eoi6",     8'hC2, 0, 1, 0, 0, 8'h00, 0, 3'd6, 8'h00, 8'h82, 0, 8'h00);
    step("next7",    8'hC2, 0, 0, 0, 0, 8'h00, 1, 3'd7, 8'h00, 8'h82, 1, 8'h00);
    step("ack7",     8'hC2, 1, 0, 0, 0, 8'h00, 0, 3'd7, 8'h80, 8'h02, 1, 8'h00);
    step("eoi7",     8'hC2, 0, 1, 0, 0, 8'h00, 0, 3'd7, 8'h00, 8'h02, 0, 8'h00);
    step("next1",    8'hC2, 0, 0, 0, 0, 8'h00, 1, 3'd1, 8'h00, 8'h02, 1, 8'h00);
    step("ack1",     8'hC2, 1, 0, 0, 0, 8'h00, 0, 3'd1, 8'h02, 8'h00, 1, 8'h00);
    step("eoi1",     8'h00, 0, 1, 0, 0, 8'h00, 0, 3'd1, 8'h00, 8'h00, 0, 8'h00);

    step("wrmask8",  8'h00, 0, 0, 0, 1, 8'h08, 0, 3'd1, 8'h00, 8'h00, 0, 8'h08);
    step("rise3m",   8'h08, 0, 0, 0, 0, 8'h00, 0, 3'd1, 8'h00, 8'h00, 0, 8'h08);
    step("held3m",   8'h08, 0, 0, 0, 0, 8'h00, 0, 3'd1, 8'h00, 8'h00, 0, 8'h08);
    step("unmask",   8'h08, 0, 0, 0, 1, 8'h00, 0, 3'd1, 8'h00, 8'h08, 0, 8'h00);
    step("req3",     8'h08, 0, 0, 0, 0, 8'h00, 1, 3'd3, 8'h00, 8'h08, 1, 8'h00);
    step("mask3a",   8'h08, 0, 0, 0, 1, 8'h08, 1, 3'd3, 8'h00, 8'h00, 1, 8'h08);
    step("ack3",     8'h08, 1, 0, 0, 0, 8'h00, 0, 3'd3, 8'h08, 8'h00, 1, 8'h08);
    step("eoi3",     8'h00, 0, 1, 0, 1, 8'h00, 0, 3'd3, 8'h00, 8'h00, 0, 8'h00);

    step("rise2",    8'h04, 0, 0, 0, 0, 8'h00, 0, 3'd3, 8'h00, 8'h04, 0, 8'h00);
    step("req2",     8'h04, 0, 0, 0, 0, 8'h00, 1, 3'd2, 8'h00, 8'h04, 1, 8'h00);
    step("strayeoi", 8'h00, 0, 1, 0, 0, 8'h00, 1, 3'd2, 8'h00, 8'h04, 1, 8'h00);
    step("ackedge2", 8'h04, 1, 0, 0, 0, 8'h00, 0, 3'd2, 8'h04, 8'h04, 1, 8'h00);
    step("eoi2",     8'h04, 0, 1, 0, 0, 8'h00, 0, 3'd2, 8'h00, 8'h04, 0, 8'h00);
    step("rereq2",   8'h04, 0, 0, 0, 0, 8'h00, 1, 3'd2, 8'h00, 8'h04, 1, 8'h00);
    step("ack2b",    8'h04, 1, 0, 0, 0, 8'h00, 0, 3'd2, 8'h04, 8'h00, 1, 8'h00);
    step("eoi2b",    8'h04, 0, 1, 0, 0, 8'h00, 0, 3'd2, 8'h00, 8'h00, 0, 8'h00);
    step("strayack", 8'h04, 1, 0, 0, 0, 8'h00, 0, 3'd2, 8'h00, 8'h00, 0, 8'h00);

    step("quiet6",   8'h00, 0, 0, 0, 0, 8'h00, 0, 3'd2, 8'h00, 8'h00, 0, 8'h00);
    step("rise4",    8'h10, 0, 0, 0, 0, 8'h00, 0, 3'd2, 8'h00, 8'h10, 0, 8'h00);
    step("req4",     8'h10, 0, 0, 0, 0, 8'h00, 1, 3'd4, 8'h00, 8'h10, 1, 8'h00);
    step("ackeoi4",  8'h13, 1, 1, 0, 0, 8'h00, 0, 3'd4, 8'h10, 8'h03, 1, 8'h00);
    step("svc4mask", 8'h13, 0, 0, 0, 1, 8'h80, 0, 3'd4, 8'h10, 8'h03, 1, 8'h80);
    step("rstmid",   8'h13, 0, 0, 1, 0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step("postrst", 8'h13, 0, 0, 0, 0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 0, 8'h00);
    end
    step("fall0",    8'h00, 0, 0, 0, 0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 0, 8'h00);
    step("rise0",    8'h01, 0, 0, 0, 0, 8'h00, 0, 3'd0, 8'h00, 8'h01, 0, 8'h00);
    step("req0",     8'h01, 0, 0, 0, 0, 8'h00, 1, 3'd0, 8'h00, 8'h01, 1, 8'h00);

    test_count++;
    assert (sb.size() == 0) else begin
      fail_count++;
      $error("[TB] FAIL scoreboard_drain observed=%0d entries expected=0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule

// File: doc/irq_request_ctrl.md
Name: irq_request_ctrl

Overview:
- Interrupt request front-end that sits around the 8-to-3 priority encoder.
- Captures rising edges on 8 request lines into a pending register and applies a mask. Drives the masked pending vector to the encoder's 8-bit input.
- Consumes the encoder's 3-bit index/valid, then runs a request/acknowledge/end-of-interrupt handshake with the CPU.
- Line 7 is highest priority, line 0 lowest; this ordering comes from the encoder.

Parameters:
- N_IRQ, 8, number of request lines; fixed at 8 to match the encoder's 8-bit input.
- IDX_W, 3, index width, log2(N_IRQ).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- irq_in  in  8  request lines, synchronous to clk; a 0->1 transition raises a request.
- mask_we  in  1  mask write strobe.
- mask_wdata  in  8  new mask value; 1 = line disabled.
- mask  out  8  current mask register.
- req_vec  out  8  pending & ~mask, to the encoder's data input.
- enc_y  in  3  encoder index output.
- enc_valid  in  1  encoder valid output.
- int_out  out  1  interrupt request to the CPU.
- int_vec  out  3  vector being requested or serviced.
- int_ack  in  1  CPU acknowledge, single-cycle pulse.
- eoi  in  1  CPU end-of-interrupt, single-cycle pulse.
- in_service  out  8  one-hot in-service line; 0 when none.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high. All registers update on the clk rising edge.
- Reset values:
  - pending, mask, in_service are 0.
  - int_out = 0, int_vec = 0, busy = 0, state = IDLE.
  - irq_prev loads irq_in during reset, so lines already high at reset release do not raise requests.
- Edge capture:
  - Each cycle, pending[i] is set when irq_in[i] & ~irq_prev[i].
  - irq_prev <= irq_in every cycle.
- Pending clear: pending[v] is cleared only on an accepted int_ack, where v = int_vec. If a new edge on line v occurs in the same cycle, set wins and pending[v] stays 1.
- Masking:
  - mask_we loads mask_wdata, effective from the next cycle.
  - Masking never clears pending bits; unmasking a pending line makes it requestable again.
- req_vec is combinational from registers: pending & ~mask.
- FSM (single level, no nesting):
  - IDLE: if enc_valid, latch int_vec <= enc_y, set int_out <= 1, go to ASSERT. Otherwise stay.
  - ASSERT:
    - int_out and int_vec are held stable, even if the source line becomes masked or a higher-priority request arrives.
    - On int_ack: clear pending[int_vec], set in_service[int_vec], int_out <= 0, go to SERVICE.
  - SERVICE: on eoi, clear in_service, go to IDLE. int_vec keeps its value until the next latch.
- Ignored inputs:
  - int_ack outside ASSERT has no effect.
  - eoi outside SERVICE has no effect.
  - int_ack and eoi together in ASSERT: only the ack is taken.
- Latency:
  - irq_in rising, sampled at edge k: pending bit is 1 after edge k, int_out is 1 after edge k+1, provided the FSM is in IDLE and the line is unmasked.
  - After eoi at edge m, state is IDLE after m. A still-pending request asserts int_out after edge m+1.
- busy = (state != IDLE).
- Reset mid-operation:
  - rst in any state returns everything to reset values in the same edge.
  - Pending and in-service are lost; no int_out glitch beyond that edge.
- enc_valid = 0 while in IDLE: remain in IDLE with int_out = 0.
- enc_y is only sampled in IDLE.

Decomposition:
- Shared include header holds:
  - state encodings: ST_IDLE = 2'd0, ST_ASSERT = 2'd1, ST_SERVICE = 2'd2;
  - constants N_IRQ and IDX_W.
- One natural sub-module: irq_edge_detect.
  - 8-bit irq_prev register with reset-load behaviour.
  - Output rise = irq_in & ~irq_prev.
- The FSM and the pending/mask/in-service registers stay in irq_request_ctrl.
- The encoder is instantiated alongside in the top level, not inside this block.

Test Plan:
- Reset with irq_in = 8'h04 held, release rst, keep irq_in = 8'h04 -> pending stays 0, int_out stays 0 for 10 cycles.
- Single request: irq_in 0->8'h20 at edge k -> req_vec = 8'h20 after k, int_out = 1 and int_vec = 5 after k+1. Pulse int_ack -> int_out = 0, in_service = 8'h20, pending = 0. Pulse eoi -> in_service = 0, busy = 0.
- Priority and hold: edges on lines 1 and 6 in the same cycle -> int_vec = 6. Line 7 edge during ASSERT -> int_vec stays 6. After ack of 6 and eoi, int_vec = 7 two cycles later, then line 1 after that service.
- Masking: mask = 8'h08, edge on line 3 -> pending[3] = 1, req_vec = 0, int_out = 0. Write mask = 0 -> int_out = 1 and int_vec = 3 one cycle after the mask is updated.
- Simultaneous events: new edge on line 2 in the same cycle as int_ack for vector 2 -> pending[2] remains 1, int_out reasserts with vector 2 after eoi. Stray int_ack in IDLE and stray eoi in ASSERT -> no state change.
- Reset mid-service: in SERVICE with in_service = 8'h10 and pending = 8'h03, assert rst for one cycle -> all outputs 0, state IDLE, no int_out until a fresh edge.
